// File: rtl/core_frame_sequencer.sv
// Per-core instruction frame receiver.
// Captures a whole frame from the scheduler broadcast bus on this core's start
// bit, optionally loads R0, then hands the frame's instructions to the core
// pipeline one at a time under valid/ready. After the last transfer (or a STOP
// opcode) it waits for the pipeline to go idle before reporting ready again.
module core_frame_sequencer #(
    parameter int       INSN_WIDTH     = 16,
    parameter int       INSN_PER_FRAME = 16,
    parameter int       REG_WIDTH      = 8,
    parameter int       OPC_MSB        = 15,
    parameter logic [3:0] STOP_OPC     = 4'hF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start_i,
    input  logic [INSN_WIDTH*INSN_PER_FRAME-1:0] insn_data_i,
    input  logic                                 init_r0_en_i,
    input  logic [REG_WIDTH-1:0]                 init_r0_i,
    output logic                                 ready_o,
    output logic                                 insn_valid_o,
    output logic [INSN_WIDTH-1:0]                insn_o,
    input  logic                                 insn_ready_i,
    input  logic                                 pipe_idle_i,
    output logic                                 r0_we_o,
    output logic [REG_WIDTH-1:0]                 r0_wdata_o,
    output logic                                 proto_err_o
);

    localparam int FRAME_W = INSN_WIDTH * INSN_PER_FRAME;
    localparam int IDX_W   = (INSN_PER_FRAME > 1) ? $clog2(INSN_PER_FRAME) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSN_PER_FRAME - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [FRAME_W-1:0]     frame_q;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   r0_we_q, r0_we_d;
    logic [REG_WIDTH-1:0]   r0_wdata_q, r0_wdata_d;
    logic                   proto_err_q, proto_err_d;
    logic                   frame_load;
    logic [INSN_WIDTH-1:0]  cur_insn;

    // Slot currently pointed at; stays stable while idx is held during a stall.
    assign cur_insn = frame_q[idx_q*INSN_WIDTH +: INSN_WIDTH];

    assign r0_we_o     = r0_we_q;
    assign r0_wdata_o  = r0_wdata_q;
    assign proto_err_o = proto_err_q;

    // Next-state and output decode; ready/valid/insn come straight from registered state.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        r0_we_d      = 1'b0;
        r0_wdata_d   = r0_wdata_q;
        proto_err_d  = proto_err_q | (start_i && (state_q != S_IDLE));
        frame_load   = 1'b0;
        ready_o      = 1'b0;
        insn_valid_o = 1'b0;
        insn_o       = '0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    frame_load = 1'b1;
                    idx_d      = '0;
                    state_d    = S_ISSUE;
                    if (init_r0_en_i) begin
                        r0_we_d    = 1'b1;
                        r0_wdata_d = init_r0_i;
                    end
                end
            end
            S_ISSUE: begin
                insn_valid_o = 1'b1;
                insn_o       = cur_insn;
                if (insn_ready_i) begin
                    if ((idx_q == LAST_IDX) || (cur_insn[OPC_MSB -: 4] == STOP_OPC)) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (pipe_idle_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            r0_we_q     <= 1'b0;
            r0_wdata_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            r0_we_q     <= r0_we_d;
            r0_wdata_q  <= r0_wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Frame storage, written only when a start is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (frame_load) begin
            frame_q <= insn_data_i;
        end
    end

endmodule

// File: tb/tb_core_frame_sequencer.sv
// Randomized self-checking bench for core_frame_sequencer.
// Reference model: the issued stream of a frame is its slots from 0 up to and
// including the first STOP opcode (or all slots); ready is low from the cycle
// after start through the drain cycles until the pipeline reports idle.
module tb_core_frame_sequencer;

    localparam int IW = 16;
    localparam int NS = 16;
    localparam int RW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [IW*NS-1:0] insn_data = '0;
    logic            init_r0_en = 1'b0;
    logic [RW-1:0]   init_r0 = '0;
    logic            ready;
    logic            insn_valid;
    logic [IW-1:0]   insn;
    logic            insn_ready = 1'b0;
    logic            pipe_idle = 1'b1;
    logic            r0_we;
    logic [RW-1:0]   r0_wdata;
    logic            proto_err;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_proto = 1'b0;

    core_frame_sequencer #(
        .INSN_WIDTH(IW), .INSN_PER_FRAME(NS), .REG_WIDTH(RW), .OPC_MSB(15), .STOP_OPC(4'hF)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start), .insn_data_i(insn_data),
        .init_r0_en_i(init_r0_en), .init_r0_i(init_r0), .ready_o(ready),
        .insn_valid_o(insn_valid), .insn_o(insn), .insn_ready_i(insn_ready),
        .pipe_idle_i(pipe_idle), .r0_we_o(r0_we), .r0_wdata_o(r0_wdata),
        .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IW*NS-1:0] rand_frame();
        logic [IW*NS-1:0] r;
        for (int i = 0; i < NS/2; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [IW*NS-1:0] ramp_frame();
        logic [IW*NS-1:0] r;
        for (int k = 0; k < NS; k++) r[k*IW +: IW] = 16'h0100 + 16'(k);
        return r;
    endfunction

    // Number of slots the frame issues: up to and including the first STOP.
    function automatic int issue_count(input logic [IW*NS-1:0] f);
        int n;
        n = NS;
        for (int k = NS-1; k >= 0; k--) if (f[k*IW+12 +: 4] == 4'hF) n = k + 1;
        return n;
    endfunction

    // mode: 0 = insn_ready always 1, 1 = pattern 1,0,0, 2 = random.
    // dwait: drain cycles with pipe_idle=0 before it goes to 1.
    // proto_at: cycle (after start) with a stray start pulse, -1 for none.
    task automatic run_frame(input logic [IW*NS-1:0] f, input bit r0en, input logic [RW-1:0] r0v,
                             input int mode, input int dwait, input int proto_at, output int low_cycles);
        int  n, issued, dleft, cyc;
        bit  done, in_issue;
        n      = issue_count(f);
        issued = 0;
        dleft  = dwait;
        cyc    = 0;
        done   = 1'b0;
        start      = 1'b1;
        insn_data  = f;
        init_r0_en = r0en;
        init_r0    = r0v;
        insn_ready = 1'($urandom);
        pipe_idle  = 1'($urandom);
        @(negedge clk);
        check("ready_idle", 32'(ready), 32'd1);
        check("valid_idle", 32'(insn_valid), 32'd0);
        @(posedge clk); #1;
        start      = 1'b0;
        insn_data  = rand_frame();
        init_r0_en = 1'($urandom);
        init_r0    = RW'($urandom);
        while (!done && cyc < 400) begin
            in_issue = (issued < n);
            case (mode)
                0:       insn_ready = 1'b1;
                1:       insn_ready = (cyc % 3 == 0);
                default: insn_ready = 1'($urandom);
            endcase
            pipe_idle = in_issue ? 1'($urandom) : (dleft == 0);
            start = (cyc == proto_at);
            if (start) insn_data = rand_frame();
            @(negedge clk);
            check("ready_busy", 32'(ready), 32'd0);
            check("valid", 32'(insn_valid), 32'(in_issue));
            if (in_issue) check("insn", 32'(insn), 32'(f[issued*IW +: IW]));
            check("proto_err", 32'(proto_err), 32'(exp_proto));
            if (cyc == 0) begin
                check("r0_we_first", 32'(r0_we), 32'(r0en));
                if (r0en) check("r0_wdata", 32'(r0_wdata), 32'(r0v));
            end else begin
                check("r0_we_later", 32'(r0_we), 32'd0);
            end
            if (start) exp_proto = 1'b1;
            if (in_issue) begin
                if (insn_ready) issued++;
            end else if (dleft > 0) begin
                dleft--;
            end else begin
                done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("frame_done", 32'(done), 32'd1);
        low_cycles = cyc;
        @(negedge clk);
        check("ready_back", 32'(ready), 32'd1);
        check("valid_back", 32'(insn_valid), 32'd0);
        check("proto_after", 32'(proto_err), 32'(exp_proto));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [IW*NS-1:0] f;
        int low;
        int stop;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(insn_valid), 32'd0);
        check("rst_insn", 32'(insn), 32'd0);
        check("rst_r0_we", 32'(r0_we), 32'd0);
        check("rst_r0_wdata", 32'(r0_wdata), 32'd0);
        check("rst_proto", 32'(proto_err), 32'd0);
        @(posedge clk); #1;

        // Full frame, one issue per cycle, R0 loaded.
        run_frame(ramp_frame(), 1'b1, 8'hA5, 0, 0, -1, low);
        check("low_cycles_full", 32'(low), 32'd17);

        // R0 load disabled.
        run_frame(ramp_frame(), 1'b0, 8'h5A, 0, 0, -1, low);

        // Early STOP in slot 3, drain held for 5 cycles.
        f = ramp_frame();
        f[3*IW +: IW] = 16'hF000;
        run_frame(f, 1'b0, 8'h00, 0, 5, -1, low);
        check("low_cycles_stop", 32'(low), 32'd10);

        // Backpressure pattern 1,0,0.
        run_frame(ramp_frame(), 1'b0, 8'h00, 1, 2, -1, low);
        check("low_cycles_bp", 32'(low), 32'd49);

        // Random frames with random stop positions and handshakes.
        for (int t = 0; t < 20; t++) begin
            f = rand_frame();
            for (int k = 0; k < NS; k++) if (f[k*IW+12 +: 4] == 4'hF) f[k*IW+12] = 1'b0;
            stop = $urandom_range(0, NS);
            if (stop < NS) f[stop*IW+12 +: 4] = 4'hF;
            run_frame(f, 1'($urandom), RW'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), -1, low);
        end

        // Stray start while issuing: error flag set and sticky, frame unaffected.
        run_frame(ramp_frame(), 1'b0, 8'h00, 0, 0, 2, low);
        run_frame(ramp_frame(), 1'b1, 8'h3C, 2, 1, -1, low);

        // Reset in the middle of a frame.
        start     = 1'b1;
        insn_data = ramp_frame();
        insn_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_proto = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_valid", 32'(insn_valid), 32'd0);
        check("midrst_proto", 32'(proto_err), 32'd0);
        check("midrst_r0_we", 32'(r0_we), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_hold_valid", 32'(insn_valid), 32'd0);
        check("midrst_hold_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;

        // Normal operation after reset.
        run_frame(ramp_frame(), 1'b1, 8'h81, 2, 2, -1, low);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
